// File: rtl/sram_fb_arbiter.sv
// sram_fb_arbiter
//   Sole owner of the off-chip 1M x 16 SRAM that holds two frame buffers.
//   The bank is selected by SRAM_ADDRESS[19]. Word accesses are arbitrated
//   between two requesters:
//     - the VGA scan-out read port, which has priority;
//     - the drawing/Nios write port, which is forced through after
//       MAX_RD_BURST consecutive read grants.
//   Front/back buffer swaps are requested at any time and applied only at
//   vertical blank.
//
// Ports
//   Clk, Reset_n                      clock, async active-low reset
//   vga_rd_req/addr -> rd_data/valid  front-buffer word read (level req, pulse done)
//   wr_req/addr/data/be -> wr_ack     back-buffer word write (level req, pulse done)
//   swap_req, vblank_start            swap request pulse, vertical blank pulse
//   swap_pending, swap_done           swap status, 1-cycle pulse when front toggles
//   front_buf                         current scan-out bank
//   SRAM_*                            SRAM pins (controls active-low, DQ tri-state)
module sram_fb_arbiter #(
  parameter int unsigned MAX_RD_BURST = 8,
  parameter bit          RESET_FRONT  = 1'b0
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        vga_rd_req,
  input  logic [18:0] vga_rd_addr,
  output logic [15:0] vga_rd_data,
  output logic        vga_rd_valid,
  input  logic        wr_req,
  input  logic [18:0] wr_addr,
  input  logic [15:0] wr_data,
  input  logic [1:0]  wr_be,
  output logic        wr_ack,
  input  logic        swap_req,
  input  logic        vblank_start,
  output logic        swap_pending,
  output logic        swap_done,
  output logic        front_buf,
  inout  wire  [15:0] SRAM_DQ,
  output logic [19:0] SRAM_ADDRESS,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  localparam logic [7:0] BURST_LIMIT = 8'(MAX_RD_BURST);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD1,
    S_RD2,
    S_WR1,
    S_WR2,
    S_WR3
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  rd_streak_q, rd_streak_d;
  logic [19:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  be_q, be_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        wr_ack_q, wr_ack_d;
  logic        front_buf_q, front_buf_d;
  logic        swap_pending_q, swap_pending_d;
  logic        swap_done_q, swap_done_d;

  logic        ce_n, oe_n, we_n, ub_n, lb_n;
  logic        dq_oe;

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q        <= S_IDLE;
      rd_streak_q    <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      be_q           <= '0;
      rd_data_q      <= '0;
      rd_valid_q     <= 1'b0;
      wr_ack_q       <= 1'b0;
      front_buf_q    <= RESET_FRONT;
      swap_pending_q <= 1'b0;
      swap_done_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      rd_streak_q    <= rd_streak_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      be_q           <= be_d;
      rd_data_q      <= rd_data_d;
      rd_valid_q     <= rd_valid_d;
      wr_ack_q       <= wr_ack_d;
      front_buf_q    <= front_buf_d;
      swap_pending_q <= swap_pending_d;
      swap_done_q    <= swap_done_d;
    end
  end

  // ---------------------------------------------------------------------
  // Access FSM: arbitration happens only on the edge leaving IDLE
  // ---------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    rd_streak_d = rd_streak_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    wr_ack_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // The bank bit is frozen here, so a swap applied while the access
        // is in flight cannot redirect it.
        if (wr_req && (!vga_rd_req || rd_streak_q == BURST_LIMIT)) begin
          state_d     = S_WR1;
          addr_d      = {~front_buf_q, wr_addr};
          wdata_d     = wr_data;
          be_d        = wr_be;
          rd_streak_d = '0;
        end else if (vga_rd_req) begin
          state_d = S_RD1;
          addr_d  = {front_buf_q, vga_rd_addr};
          if (wr_req) begin
            rd_streak_d = rd_streak_q + 8'd1;
          end
        end
      end
      S_RD1: state_d = S_RD2;
      S_RD2: begin
        state_d    = S_IDLE;
        rd_data_d  = SRAM_DQ;
        rd_valid_d = 1'b1;
      end
      S_WR1: state_d = S_WR2;
      S_WR2: state_d = S_WR3;
      S_WR3: begin
        state_d  = S_IDLE;
        wr_ack_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // The streak only measures reads that overtook a waiting write.
    if (!wr_req) begin
      rd_streak_d = '0;
    end
  end

  // ---------------------------------------------------------------------
  // Front/back buffer swap, applied only at vertical blank
  // ---------------------------------------------------------------------
  always_comb begin
    front_buf_d    = front_buf_q;
    swap_pending_d = swap_pending_q;
    swap_done_d    = 1'b0;

    if (vblank_start && (swap_pending_q || swap_req)) begin
      front_buf_d    = ~front_buf_q;
      swap_pending_d = 1'b0;
      swap_done_d    = 1'b1;
    end else if (swap_req) begin
      swap_pending_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // SRAM pin decode straight from the state register, so an async reset
  // releases the bus without waiting for a clock edge.
  // ---------------------------------------------------------------------
  always_comb begin
    ce_n  = 1'b1;
    oe_n  = 1'b1;
    we_n  = 1'b1;
    ub_n  = 1'b1;
    lb_n  = 1'b1;
    dq_oe = 1'b0;

    unique case (state_q)
      S_RD1, S_RD2: begin
        ce_n = 1'b0;
        oe_n = 1'b0;
        ub_n = 1'b0;
        lb_n = 1'b0;
      end
      S_WR1, S_WR3: begin
        ce_n  = 1'b0;
        ub_n  = ~be_q[1];
        lb_n  = ~be_q[0];
        dq_oe = 1'b1;
      end
      S_WR2: begin
        ce_n  = 1'b0;
        we_n  = 1'b0;
        ub_n  = ~be_q[1];
        lb_n  = ~be_q[0];
        dq_oe = 1'b1;
      end
      default: ;
    endcase
  end

  assign SRAM_DQ      = dq_oe ? wdata_q : 16'hzzzz;
  assign SRAM_ADDRESS = addr_q;
  assign SRAM_CE_N    = ce_n;
  assign SRAM_OE_N    = oe_n;
  assign SRAM_WE_N    = we_n;
  assign SRAM_UB_N    = ub_n;
  assign SRAM_LB_N    = lb_n;

  assign vga_rd_data  = rd_data_q;
  assign vga_rd_valid = rd_valid_q;
  assign wr_ack       = wr_ack_q;
  assign front_buf    = front_buf_q;
  assign swap_pending = swap_pending_q;
  assign swap_done    = swap_done_q;

endmodule

// File: tb/tb_sram_fb_arbiter.sv
// tb_sram_fb_arbiter
//   Bench for sram_fb_arbiter with a behavioural SRAM model on the pins.
//   Read data and write addresses are scoreboarded: the expectation is
//   queued when a request is driven and retired on vga_rd_valid / wr_ack.
module tb_sram_fb_arbiter;

  logic        Clk;
  logic        Reset_n;
  logic        vga_rd_req;
  logic [18:0] vga_rd_addr;
  logic [15:0] vga_rd_data;
  logic        vga_rd_valid;
  logic        wr_req;
  logic [18:0] wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;
  logic        wr_ack;
  logic        swap_req;
  logic        vblank_start;
  logic        swap_pending;
  logic        swap_done;
  logic        front_buf;
  wire  [15:0] sram_dq;
  logic [19:0] SRAM_ADDRESS;
  logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;

  sram_fb_arbiter #(
    .MAX_RD_BURST(8),
    .RESET_FRONT (1'b0)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .vga_rd_req  (vga_rd_req),
    .vga_rd_addr (vga_rd_addr),
    .vga_rd_data (vga_rd_data),
    .vga_rd_valid(vga_rd_valid),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_be       (wr_be),
    .wr_ack      (wr_ack),
    .swap_req    (swap_req),
    .vblank_start(vblank_start),
    .swap_pending(swap_pending),
    .swap_done   (swap_done),
    .front_buf   (front_buf),
    .SRAM_DQ     (sram_dq),
    .SRAM_ADDRESS(SRAM_ADDRESS),
    .SRAM_CE_N   (SRAM_CE_N),
    .SRAM_OE_N   (SRAM_OE_N),
    .SRAM_WE_N   (SRAM_WE_N),
    .SRAM_UB_N   (SRAM_UB_N),
    .SRAM_LB_N   (SRAM_LB_N)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ------------------------------------------------------------------
  // Behavioural SRAM
  // ------------------------------------------------------------------
  logic [15:0] smem [bit [19:0]];
  logic [15:0] sram_rdata;
  logic        sram_oe;

  assign sram_oe = !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;
  assign sram_dq = sram_oe ? sram_rdata : 16'hzzzz;

  always @(negedge Clk) begin
    sram_rdata <= smem.exists(SRAM_ADDRESS) ? smem[SRAM_ADDRESS] : 16'h0000;
  end

  always @(posedge Clk) begin : sram_write
    logic [15:0] w;
    if (!SRAM_CE_N && !SRAM_WE_N) begin
      w = smem.exists(SRAM_ADDRESS) ? smem[SRAM_ADDRESS] : 16'h0000;
      if (!SRAM_UB_N) w[15:8] = sram_dq[15:8];
      if (!SRAM_LB_N) w[7:0]  = sram_dq[7:0];
      smem[SRAM_ADDRESS] = w;
    end
  end

  // ------------------------------------------------------------------
  // Checking infrastructure
  // ------------------------------------------------------------------
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [15:0] rq[$];      // expected read data
  logic [19:0] wq[$];      // expected SRAM address of each write
  bit          grants[$];  // 1 = write grant, 0 = read grant
  bit          logging = 1'b0;
  logic        prev_ce_n = 1'b1;
  logic [19:0] last_we_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: sample on the falling edge and retire scoreboard entries.
  task automatic tick();
    @(negedge Clk);
    if (vga_rd_valid) begin
      if (rq.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL rd_valid_unexpected: got valid with data 0x%0h, expected no valid", vga_rd_data);
      end else begin
        check("rd_data", vga_rd_data, rq.pop_front());
      end
    end
    if (wr_ack) begin
      if (wq.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL wr_ack_unexpected: got ack, expected no ack");
      end else begin
        check("wr_addr_at_we", last_we_addr, wq.pop_front());
      end
    end
    if (!SRAM_WE_N) last_we_addr = SRAM_ADDRESS;
    if (logging && !SRAM_CE_N && prev_ce_n) grants.push_back(SRAM_OE_N);
    prev_ce_n = SRAM_CE_N;
  endtask

  typedef struct {
    logic [18:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
    logic [19:0] exp_sram_addr;
    logic        exp_ub_n;
    logic        exp_lb_n;
  } wr_vec_t;

  typedef struct {
    logic [18:0] addr;
    logic [19:0] exp_sram_addr;
    logic [15:0] exp_data;
  } rd_vec_t;

  task automatic do_write(input wr_vec_t v);
    int  n;
    int  we_cycles;
    int  we_tick;
    bit  done;
    n = 0; we_cycles = 0; we_tick = 0; done = 1'b0;
    wr_req = 1'b1; wr_addr = v.addr; wr_data = v.data; wr_be = v.be;
    wq.push_back(v.exp_sram_addr);
    while (!done && n < 12) begin
      tick();
      n++;
      if (!SRAM_CE_N) begin
        check("wr_sram_addr", SRAM_ADDRESS, v.exp_sram_addr);
        check("wr_dq", sram_dq, v.data);
        check("wr_oe_n", SRAM_OE_N, 1'b1);
        check("wr_ub_n", SRAM_UB_N, v.exp_ub_n);
        check("wr_lb_n", SRAM_LB_N, v.exp_lb_n);
      end
      if (!SRAM_WE_N) begin
        we_cycles++;
        we_tick = n;
      end
      if (wr_ack) done = 1'b1;
    end
    wr_req = 1'b0;
    check("wr_ack_seen", done, 1'b1);
    check("wr_ack_latency", n, 4);
    check("wr_we_low_cycles", we_cycles, 1);
    check("wr_we_low_slot", we_tick, 2);
  endtask

  task automatic do_read(input rd_vec_t v);
    int n;
    bit done;
    n = 0; done = 1'b0;
    vga_rd_req = 1'b1; vga_rd_addr = v.addr;
    rq.push_back(v.exp_data);
    while (!done && n < 12) begin
      tick();
      n++;
      if (!SRAM_CE_N) begin
        check("rd_sram_addr", SRAM_ADDRESS, v.exp_sram_addr);
        check("rd_oe_we", {SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}, 4'b0100);
      end
      if (vga_rd_valid) done = 1'b1;
    end
    vga_rd_req = 1'b0;
    check("rd_valid_seen", done, 1'b1);
    check("rd_valid_latency", n, 3);
  endtask

  task automatic check_idle_pins(input string name);
    check(name, {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}, 5'b11111);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ------------------------------------------------------------------
  // Stimulus
  // ------------------------------------------------------------------
  wr_vec_t wv[5];
  rd_vec_t rv[4];

  initial begin : main
    bit ok;
    int n;

    wv[0] = '{addr: 19'h00010, data: 16'hBEEF, be: 2'b11, exp_sram_addr: 20'h80010, exp_ub_n: 1'b0, exp_lb_n: 1'b0};
    wv[1] = '{addr: 19'h00020, data: 16'h5566, be: 2'b11, exp_sram_addr: 20'h80020, exp_ub_n: 1'b0, exp_lb_n: 1'b0};
    wv[2] = '{addr: 19'h00020, data: 16'h12AB, be: 2'b01, exp_sram_addr: 20'h80020, exp_ub_n: 1'b1, exp_lb_n: 1'b0};
    wv[3] = '{addr: 19'h00030, data: 16'hA1B2, be: 2'b10, exp_sram_addr: 20'h80030, exp_ub_n: 1'b0, exp_lb_n: 1'b1};
    wv[4] = '{addr: 19'h00010, data: 16'hFFFF, be: 2'b00, exp_sram_addr: 20'h80010, exp_ub_n: 1'b1, exp_lb_n: 1'b1};

    rv[0] = '{addr: 19'h00010, exp_sram_addr: 20'h80010, exp_data: 16'hBEEF};
    rv[1] = '{addr: 19'h00020, exp_sram_addr: 20'h80020, exp_data: 16'h55AB};
    rv[2] = '{addr: 19'h00030, exp_sram_addr: 20'h80030, exp_data: 16'hA100};
    rv[3] = '{addr: 19'h00040, exp_sram_addr: 20'h80040, exp_data: 16'h0000};

    Reset_n = 1'b0;
    vga_rd_req = 1'b0; vga_rd_addr = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    swap_req = 1'b0; vblank_start = 1'b0;

    #2;
    check_idle_pins("reset_pins");
    check("reset_addr", SRAM_ADDRESS, 20'h00000);
    check("reset_flags", {vga_rd_valid, wr_ack, swap_done, swap_pending, front_buf}, 5'b00000);
    check("reset_rd_data", vga_rd_data, 16'h0000);
    repeat (3) tick();
    Reset_n = 1'b1;
    repeat (2) tick();
    check_idle_pins("idle_pins");

    // Writes into the back bank (bank 1 while front is 0)
    for (int i = 0; i < 5; i++) do_write(wv[i]);

    // Asynchronous reset while idle, away from any clock edge
    tick();
    #2 Reset_n = 1'b0;
    #1;
    check_idle_pins("idle_reset_pins");
    check("idle_reset_addr", SRAM_ADDRESS, 20'h00000);
    check("idle_reset_flags", {vga_rd_valid, wr_ack, swap_done, swap_pending, front_buf}, 5'b00000);
    tick();
    Reset_n = 1'b1;
    tick();

    // vblank with nothing pending does nothing
    vblank_start = 1'b1; tick(); vblank_start = 1'b0;
    check("vblank_no_pending", {front_buf, swap_done, swap_pending}, 3'b000);

    // Swap requested, held pending across a repeated request, applied at vblank
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    check("swap_pending_set", swap_pending, 1'b1);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      swap_req = (i == 7);
      tick();
      if (!(swap_pending === 1'b1 && front_buf === 1'b0 && swap_done === 1'b0)) ok = 1'b0;
    end
    swap_req = 1'b0;
    check("swap_held_pending", ok, 1'b1);
    vblank_start = 1'b1; tick(); vblank_start = 1'b0;
    check("swap_applied", {front_buf, swap_done, swap_pending}, 3'b110);
    tick();
    check("swap_done_one_cycle", {front_buf, swap_done, swap_pending}, 3'b100);

    // Old back bank is now the front: read back including byte-masked words
    for (int i = 0; i < 4; i++) do_read(rv[i]);

    // Both requesters held: eight reads then one write, repeating
    logging = 1'b1;
    grants.delete();
    vga_rd_req = 1'b1; vga_rd_addr = 19'h00010; rq.push_back(16'hBEEF);
    wr_req = 1'b1; wr_addr = 19'h00100; wr_data = 16'h7777; wr_be = 2'b11; wq.push_back(20'h00100);
    for (int c = 0; c < 60; c++) begin
      tick();
      if (vga_rd_valid) rq.push_back(16'hBEEF);
      if (wr_ack) wq.push_back(20'h00100);
    end
    n = 0;
    while ((vga_rd_req || wr_req) && n < 40) begin
      tick();
      n++;
      if (vga_rd_valid) vga_rd_req = 1'b0;
      if (wr_ack) wr_req = 1'b0;
    end
    logging = 1'b0;
    check("arb_wind_down", {vga_rd_req, wr_req}, 2'b00);
    check("arb_rq_drained", rq.size(), 0);
    check("arb_wq_drained", wq.size(), 0);
    check("arb_grant_count_min", grants.size() >= 18, 1'b1);
    for (int i = 0; i < 18 && i < grants.size(); i++) begin
      check($sformatf("arb_grant_%0d", i), grants[i], (i % 9) == 8);
    end

    // Reset in the middle of WE_N low aborts the write with no ack
    tick();
    wr_req = 1'b1; wr_addr = 19'h00200; wr_data = 16'h1234; wr_be = 2'b11;
    wq.push_back(20'h00200);
    n = 0;
    while (SRAM_WE_N && n < 10) begin
      tick();
      n++;
    end
    check("abort_reached_wr2", SRAM_WE_N, 1'b0);
    #2 Reset_n = 1'b0;
    #1;
    check_idle_pins("abort_pins_released");
    check("abort_flags", {wr_ack, front_buf, swap_pending}, 3'b000);
    if (wq.size() > 0) void'(wq.pop_back());
    wr_req = 1'b0;
    repeat (2) tick();
    Reset_n = 1'b1;
    repeat (3) tick();
    check_idle_pins("abort_idle_after_release");
    begin
      wr_vec_t v;
      v = '{addr: 19'h00200, data: 16'h4321, be: 2'b11, exp_sram_addr: 20'h80200, exp_ub_n: 1'b0, exp_lb_n: 1'b0};
      do_write(v);
    end

    // swap_req and vblank in the same cycle apply immediately
    swap_req = 1'b1; vblank_start = 1'b1; tick();
    swap_req = 1'b0; vblank_start = 1'b0;
    check("swap_same_cycle", {front_buf, swap_done, swap_pending}, 3'b110);
    begin
      rd_vec_t r;
      r = '{addr: 19'h00200, exp_sram_addr: 20'h80200, exp_data: 16'h4321};
      do_read(r);
    end

    repeat (3) tick();
    check("final_rq_empty", rq.size(), 0);
    check("final_wq_empty", wq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
